// File: rtl/led_seq_pkg.sv
// Shared mode encodings, seed value and small helpers for the LED sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_SHIFT = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  localparam logic [7:0] SHIFT_SEED = 8'h01;

  function automatic mode_e next_mode(input mode_e cur);
    mode_e nxt;
    case (cur)
      MODE_PASS:  nxt = MODE_SHIFT;
      MODE_SHIFT: nxt = MODE_COUNT;
      MODE_COUNT: nxt = MODE_HOLD;
      MODE_HOLD:  nxt = MODE_PASS;
      default:    nxt = MODE_PASS;
    endcase
    return nxt;
  endfunction

  // Walking-one rotate: bit 7 re-enters at bit 0.
  function automatic logic [7:0] rotl8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop sync, optional debouncer (LED_SEQ_DEBOUNCE_EN),
// and a registered rising-edge pulse.
module btn_conditioner #(
  parameter int unsigned DB_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync1_r;
  logic sync2_r;
  logic level_s;
  logic prev_r;
  logic pulse_r;

  // Bring the raw button into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);

  logic [CW-1:0] db_cnt_r;
  logic          db_r;

  // Accept a new level only after DB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_r <= {CW{1'b0}};
      db_r     <= 1'b0;
    end else if (sync2_r == db_r) begin
      db_cnt_r <= {CW{1'b0}};
    end else if (db_cnt_r == DB_MAX) begin
      db_cnt_r <= {CW{1'b0}};
      db_r     <= sync2_r;
    end else begin
      db_cnt_r <= db_cnt_r + CW'(1);
    end
  end

  assign level_s = db_r;
`else
  assign level_s = sync2_r;
`endif

  // One registered pulse per rising edge of the conditioned level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r  <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      prev_r  <= level_s;
      pulse_r <= level_s & ~prev_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/led_sequencer.sv
// LED bank controller: pass-through, walking-one, counter and frozen snapshot modes,
// stepped by one button. Button debounce is enabled with LED_SEQ_DEBOUNCE_EN.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned DB_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic       btn_mode,
  output logic [7:0] led,
  output logic [1:0] mode
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [7:0]    sw_meta_r;
  logic [7:0]    sw_sync_r;
  logic [PW-1:0] presc_r;
  logic [7:0]    step_cnt_r;
  logic [7:0]    shift_r;
  logic [7:0]    count_r;
  logic [7:0]    hold_r;
  logic [7:0]    led_r;
  mode_e         state_r;
  mode_e         state_nx_s;
  logic [7:0]    led_nx_s;
  logic          tick_s;
  logic          step_s;
  logic          mode_adv_s;
  logic          enter_shift_s;
  logic          enter_count_s;
  logic          enter_hold_s;

  btn_conditioner #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_mode),
    .pulse (mode_adv_s)
  );

  // Switch synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_r <= 8'h00;
      sw_sync_r <= 8'h00;
    end else begin
      sw_meta_r <= sw;
      sw_sync_r <= sw_meta_r;
    end
  end

  // Free-running base-tick prescaler; mode changes never disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= {PW{1'b0}};
    end else if (presc_r == PRESC_MAX) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  assign tick_s = (presc_r == PRESC_MAX);
  // >= rather than == so lowering the switches mid-count steps on the next tick.
  assign step_s = tick_s && (step_cnt_r >= sw_sync_r);

  // Next-state, entry strobes and LED source selection.
  always_comb begin
    state_nx_s    = state_r;
    enter_shift_s = 1'b0;
    enter_count_s = 1'b0;
    enter_hold_s  = 1'b0;
    led_nx_s      = 8'h00;
    if (mode_adv_s) begin
      state_nx_s = next_mode(state_r);
    end else begin
      state_nx_s = state_r;
    end
    if (mode_adv_s) begin
      enter_shift_s = (state_nx_s == MODE_SHIFT);
      enter_count_s = (state_nx_s == MODE_COUNT);
      enter_hold_s  = (state_nx_s == MODE_HOLD);
    end else begin
      enter_shift_s = 1'b0;
      enter_count_s = 1'b0;
      enter_hold_s  = 1'b0;
    end
    case (state_r)
      MODE_PASS:  led_nx_s = sw_sync_r;
      MODE_SHIFT: led_nx_s = shift_r;
      MODE_COUNT: led_nx_s = count_r;
      MODE_HOLD:  led_nx_s = hold_r;
      default:    led_nx_s = 8'h00;
    endcase
  end

  // Mode state register; it also drives the mode output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= MODE_PASS;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Step counter, restarted on entry to an animated mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_r <= 8'h00;
    end else if (enter_shift_s || enter_count_s) begin
      step_cnt_r <= 8'h00;
    end else if (step_s) begin
      step_cnt_r <= 8'h00;
    end else if (tick_s) begin
      step_cnt_r <= step_cnt_r + 8'd1;
    end
  end

  // Pattern registers; a mode advance in the same cycle swallows the step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= SHIFT_SEED;
      count_r <= 8'h00;
      hold_r  <= 8'h00;
    end else if (mode_adv_s) begin
      if (enter_shift_s) begin
        shift_r <= SHIFT_SEED;
      end
      if (enter_count_s) begin
        count_r <= 8'h00;
      end
      if (enter_hold_s) begin
        hold_r <= led_r;
      end
    end else if (step_s) begin
      if (state_r == MODE_SHIFT) begin
        shift_r <= rotl8(shift_r);
      end
      if (state_r == MODE_COUNT) begin
        count_r <= count_r + 8'd1;
      end
    end
  end

  // Registered LED drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r <= 8'h00;
    end else begin
      led_r <= led_nx_s;
    end
  end

  assign led  = led_r;
  assign mode = state_r;

endmodule
